if_fetch_unit: RTL and testbench

//  Instruction-fetch front end of the RV32I core: owns the fetch PC, issues in-order reads to the

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_sync_fifo.sv | 52 +++++
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions.
//   XLEN      : address/data width
//   INST_W    : instruction word width
//   RESET_PC  : fetch PC after reset
//   NOP_INST  : addi x0,x0,0, presented to ID whenever no instruction is buffered
//   if_entry_t: one buffered fetch result {pc, inst}
package riscv_pkg;

    localparam int                  XLEN     = 32;
    localparam int                  INST_W   = 32;
    localparam logic [XLEN-1:0]     RESET_PC = '0;
    localparam logic [INST_W-1:0]   NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } if_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous circular FIFO with a flush input.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the FIFO at the next edge (wins over push/pop)
//   push, wdata   : write one entry (caller guarantees !full || pop)
//   pop           : drop the head entry (caller guarantees !empty)
//   rdata         : head entry, straight from storage (no path from wdata)
//   empty, full   : derived from the wrap-bit pointers
//   count         : number of stored entries
module if_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // At full occupancy a simultaneous push lands in the slot being popped;
    // the old head is read out this cycle, the new word is written at the edge.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch front end.
// Owns the fetch PC, issues in-order reads to instruction memory and buffers
// returned words (with their PC) for decode. A tag queue remembers the PC of
// every accepted request; responses pop it in order. Requests are credit
// limited so that in-flight requests plus buffered words never exceed DEPTH.
//   clk, rst                      : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr : read request channel (imem_addr == pc)
//   imem_rsp_valid, imem_rsp_data : in-order read responses
//   redirect_valid, redirect_pc   : flush and restart fetch at a new target
//   id_ready                      : decode consumes the head this cycle
//   if_valid, if_pc, if_inst      : buffered head entry for decode
//   pc                            : live fetch PC register
module if_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        discard;
    logic [CW-1:0]        occupancy;
    logic [CW:0]          committed;
    logic                 issue;
    logic                 rsp_take;
    logic                 rsp_keep;
    logic                 buf_pop;

    logic [XLEN-1:0]      tag_pc;
    logic                 tag_empty;
    logic                 tag_full;
    logic [CW-1:0]        tag_count;

    logic                 buf_empty;
    logic                 buf_full;
    riscv_pkg::if_entry_t wr_entry;
    riscv_pkg::if_entry_t head;

    // A word popped by ID this cycle frees its slot immediately, which is what
    // lets a DEPTH=2 buffer sustain one instruction per cycle.
    assign buf_pop   = if_valid && id_ready && !redirect_valid;
    assign committed = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, buf_pop};

    assign imem_req_valid = !rst && !redirect_valid && (committed < CREDITS);
    assign imem_addr      = pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are a protocol error and are ignored.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    // A response in a redirect cycle, or one owed to a pre-redirect request,
    // is consumed (tag popped) but never reaches the buffer.
    assign rsp_keep = rsp_take && !redirect_valid && (discard == '0);

    assign wr_entry.pc   = tag_pc;
    assign wr_entry.inst = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp_take);
            if (redirect_valid) begin
                pc      <= {redirect_pc[XLEN-1:2], 2'b00};
                // Every request still in flight after this edge belongs to the
                // old path; back-to-back redirects recompute from the same count.
                discard <= outstanding - CW'(rsp_take);
            end else begin
                if (issue) pc <= pc + XLEN'(4);
                if (rsp_take && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

    // PCs of accepted requests, popped in order by responses. Not flushed on
    // redirect: stale responses still need their tag popped.
    if_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (issue),
        .wdata (pc),
        .pop   (rsp_take),
        .rdata (tag_pc),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    if_sync_fifo #(
        .DEPTH ($bits(riscv_pkg::if_entry_t) > 0 ? DEPTH : DEPTH),
        .WIDTH ($bits(riscv_pkg::if_entry_t))
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .wdata (wr_entry),
        .pop   (buf_pop),
        .rdata (head),
        .empty (buf_empty),
        .full  (buf_full),
        .count (occupancy)
    );

    assign if_valid = !buf_empty;
    assign if_pc    = buf_empty ? '0 : head.pc;
    assign if_inst  = buf_empty ? riscv_pkg::NOP_INST : head.inst;

    a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));
    a_tag_count: assert property (@(posedge clk) disable iff (rst)
        (tag_count == outstanding) && (tag_empty == (outstanding == '0)));
    a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
        !(tag_full && issue));
    a_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_full && rsp_keep && !buf_pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc;

    int n_chk  = 0;
    int n_pass = 0;
    int ncons  = 0;

    logic [31:0] sb[$];
    logic [31:0] mq[$];
    logic [31:0] mon_e;
    int          nacc = 0;
    logic        mem_hold  = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        s_hs, s_rsp, s_rst;
    logic [31:0] s_addr;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .pc             (pc)
    );

    // Memory image: word at address a is {a[15:0], 16'h0093}.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) sb.push_back(base + 32'(4 * k));
    endtask

    task automatic wait_cons(input string name, input int n);
        int tgt;
        int c;
        tgt = ncons + n;
        c   = 0;
        while (ncons < tgt && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(name, 64'(ncons >= tgt), 64'd1);
    endtask

    // Instruction memory: in-order, responds the cycle after accept unless held.
    always begin
        @(negedge clk);
        s_hs   = imem_req_valid && imem_req_ready;
        s_addr = imem_addr;
        s_rsp  = imem_rsp_valid;
        s_rst  = rst;
        @(posedge clk);
        #2;
        if (s_rst) begin
            mq.delete();
            nacc = 0;
        end else begin
            if (s_rsp && mq.size() > 0) void'(mq.pop_front());
            if (s_hs) begin
                mq.push_back(s_addr);
                nacc++;
            end
        end
        imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        imem_rsp_valid = !mem_hold && (mq.size() != 0);
        imem_rsp_data  = (mq.size() != 0) ? inst_of(mq[0]) : 32'h0;
    end

    // Monitor: every instruction ID actually consumes must be the next expected one.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && if_valid && id_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: if_pc %h delivered, nothing expected", if_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_pc", 64'(if_pc), 64'(mon_e));
                chk("sb_inst", 64'(if_inst), 64'(inst_of(mon_e)));
            end
            ncons++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end

    initial begin
        int start;
        int c;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        // 1: reset state, first request address
        repeat (2) @(posedge clk);
        #1;
        chk("t1_pc", 64'(pc), 64'h0);
        chk("t1_req_valid", 64'(imem_req_valid), 64'h0);
        chk("t1_if_valid", 64'(if_valid), 64'h0);
        chk("t1_if_pc", 64'(if_pc), 64'h0);
        chk("t1_if_inst", 64'(if_inst), 64'h13);
        push_run(32'h0, 64);
        rst = 1'b0;
        #1;
        chk("t1_first_req", 64'(imem_req_valid), 64'h1);
        chk("t1_first_addr", 64'(imem_addr), 64'h0);

        // 2: streaming, one instruction per cycle from 2 cycles after reset
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_stream", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, 32'(4 * i)});
            @(posedge clk);
        end
        #1;

        // 3: decode stalled from reset
        rst      = 1'b1;
        id_ready = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        push_run(32'h0, 64);
        repeat (5) tick();
        chk("t3_pc_frozen", 64'(pc), 64'h8);
        chk("t3_no_req", 64'(imem_req_valid), 64'h0);
        chk("t3_accepted", 64'(nacc), 64'd2);
        chk("t3_head", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, 32'h0});
        id_ready = 1'b1;
        wait_cons("t3_drain", 6);

        // 4: redirect to 0x103 with two requests in flight
        mem_hold = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((if_valid || imem_req_valid) && c < 30);
        @(posedge clk);
        #1;
        chk("t4_two_in_flight", 64'(mq.size()), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        sb.delete();
        push_run(32'h100, 64);
        tick();
        redirect_valid = 1'b0;
        chk("t4_pc", 64'(pc), 64'h100);
        chk("t4_addr", 64'(imem_addr), 64'h100);
        chk("t4_flushed", 64'(if_valid), 64'h0);
        mem_hold = 1'b0;
        wait_cons("t4_resume", 4);

        // 5a: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb.delete();
        sb.push_back(32'hFFFF_FFFC);
        push_run(32'h0, 16);
        tick();
        redirect_valid = 1'b0;
        chk("t5_pc_top", 64'(pc), 64'hFFFF_FFFC);
        tick();
        chk("t5_pc_wrap", 64'(pc), 64'h0);
        wait_cons("t5_wrap_stream", 3);

        // 5b: reset coincident with redirect and a response
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sb.delete();
        tick();
        redirect_valid = 1'b0;
        chk("t5_rst_pc", 64'(pc), 64'h0);
        chk("t5_rst_if_valid", 64'(if_valid), 64'h0);
        chk("t5_rst_if_inst", 64'(if_inst), 64'h13);
        chk("t5_rst_req", 64'(imem_req_valid), 64'h0);
        tick();
        rst = 1'b0;
        push_run(32'h0, 64);
        wait_cons("t5_restart", 4);

        // 6: random memory ready and decode stalls
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        sb.delete();
        push_run(32'h400, 560);
        tick();
        redirect_valid = 1'b0;
        rnd_ready      = 1'b1;
        start          = ncons;
        repeat (500) begin
            id_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rnd_ready = 1'b0;
        id_ready  = 1'b1;
        wait_cons("t6_tail", 2);
        chk("t6_progress", 64'((ncons - start) >= 100), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
